hazard_fwd_ctrl: RTL and testbench

- Parametrised successor to the EX-stage forwarding unit: keeps MEM/WB operand forwarding and adds ID-stage hazard detection.
- Stalls IF/ID and injects an EX bubble on load-use hazards.
- Tracks one outstanding fixed-latency multi-cycle (MUL/DIV) operation through a scoreboard FSM.
- Sits beside the pipeline registers; drives the operand muxes, pipeline-enable controls and a saturating stall-cycle counter.

---
 rtl/hazard_fwd_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// EX-stage operand forwarding, ID-stage load-use / multi-cycle hazard detection,
// single-entry multi-cycle scoreboard FSM and a saturating stall-cycle counter.
module hazard_fwd_ctrl #(
  parameter int unsigned AW     = 5,
  parameter int unsigned MC_LAT = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1_ID,
  input  logic [AW-1:0]    rs2_ID,
  input  logic             mc_req_ID,
  input  logic             RegWen_ID,
  input  logic [AW-1:0]    rd_ID,
  input  logic [AW-1:0]    rs1_EX,
  input  logic [AW-1:0]    rs2_EX,
  input  logic [AW-1:0]    rd_EX,
  input  logic             ASel_EX,
  input  logic             MemRead_EX,
  input  logic             RegWen_EX,
  input  logic             mc_start_EX,
  input  logic [AW-1:0]    rd_MEM,
  input  logic [AW-1:0]    rd_WB,
  input  logic             RegWen_MEM,
  input  logic             RegWen_WB,
  output logic [1:0]       forwardA_EX,
  output logic [1:0]       forwardB_EX,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             bubble_EX,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [AW-1:0]    mc_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned LW = 4;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   mc_rd_q, mc_rd_d;
  logic            ld_haz, mc_haz, stall;
  logic [1:0]      fwd_a, fwd_b;

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
    end
  end

  // Next state; an issue while BUSY is ignored, an issue in DONE reloads
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mc_start_EX) begin
          state_d = S_BUSY;
          cnt_d   = LW'(MC_LAT - 1);
          mc_rd_d = rd_EX;
        end
      end
      S_BUSY: begin
        mc_busy = 1'b1;
        cnt_d   = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        mc_busy = 1'b1;
        mc_done = 1'b1;
        if (mc_start_EX) begin
          state_d = S_BUSY;
          cnt_d   = LW'(MC_LAT - 1);
          mc_rd_d = rd_EX;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand forwarding: PC select wins, then MEM, then WB
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ASel_EX)
      fwd_a = 2'b01;
    else if (RegWen_MEM && rs1_EX == rd_MEM && rs1_EX != AW'(0))
      fwd_a = 2'b11;
    else if (RegWen_WB && rs1_EX == rd_WB && rs1_EX != AW'(0))
      fwd_a = 2'b10;
    if (RegWen_MEM && rs2_EX == rd_MEM && rs2_EX != AW'(0))
      fwd_b = 2'b11;
    else if (RegWen_WB && rs2_EX == rd_WB && rs2_EX != AW'(0))
      fwd_b = 2'b10;
  end

  always_comb begin
    ld_haz = MemRead_EX && RegWen_EX && rd_EX != AW'(0) &&
             (rd_EX == rs1_ID || rd_EX == rs2_ID);
    mc_haz = (state_q == S_BUSY) &&
             ((mc_rd_q != AW'(0) &&
               (rs1_ID == mc_rd_q || rs2_ID == mc_rd_q || (RegWen_ID && rd_ID == mc_rd_q))) ||
              mc_req_ID);
    stall  = rst_n && (ld_haz || mc_haz);
  end

  // Combinational outputs are forced low while reset is held
  assign forwardA_EX = rst_n ? fwd_a : 2'b00;
  assign forwardB_EX = rst_n ? fwd_b : 2'b00;
  assign stall_IF    = stall;
  assign stall_ID    = stall;
  assign bubble_EX   = stall;
  assign mc_rd       = mc_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl (AW=5, MC_LAT=4, CNT_W=16).
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rs1_ID, rs2_ID, rd_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic        mc_req_ID, RegWen_ID, ASel_EX, MemRead_EX, RegWen_EX, mc_start_EX;
  logic        RegWen_MEM, RegWen_WB;
  logic [1:0]  forwardA_EX, forwardB_EX;
  logic        stall_IF, stall_ID, bubble_EX, mc_busy, mc_done;
  logic [4:0]  mc_rd;
  logic [15:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  hazard_fwd_ctrl #(.AW(5), .MC_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .mc_req_ID(mc_req_ID),
    .RegWen_ID(RegWen_ID), .rd_ID(rd_ID),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX), .rd_EX(rd_EX),
    .ASel_EX(ASel_EX), .MemRead_EX(MemRead_EX), .RegWen_EX(RegWen_EX),
    .mc_start_EX(mc_start_EX),
    .rd_MEM(rd_MEM), .rd_WB(rd_WB), .RegWen_MEM(RegWen_MEM), .RegWen_WB(RegWen_WB),
    .forwardA_EX(forwardA_EX), .forwardB_EX(forwardB_EX),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
    .mc_busy(mc_busy), .mc_done(mc_done), .mc_rd(mc_rd), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Protocol monitor: an issue while BUSY (not DONE) is illegal stimulus
  always @(posedge clk) begin
    if (rst_n && mc_start_EX && mc_busy && !mc_done)
      $error("protocol: mc_start_EX asserted while multi-cycle unit busy");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {rs1_ID, rs2_ID, rd_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB} = '0;
    {mc_req_ID, RegWen_ID, ASel_EX, MemRead_EX, RegWen_EX, mc_start_EX} = '0;
    {RegWen_MEM, RegWen_WB} = '0;
  endtask

  task automatic test_reset();
    clr();
    ASel_EX = 1'b1; MemRead_EX = 1'b1; RegWen_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (forwardA_EX !== 2'b00) begin errors++; $display("FAIL reset_fwdA: got %b exp 00", forwardA_EX); end
    checks++; if ({stall_IF, stall_ID, bubble_EX} !== 3'b000) begin errors++; $display("FAIL reset_stall: got %b exp 000", {stall_IF, stall_ID, bubble_EX}); end
    checks++; if ({mc_busy, mc_done} !== 2'b00) begin errors++; $display("FAIL reset_mc: got %b exp 00", {mc_busy, mc_done}); end
    checks++; if (mc_rd !== 5'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_regs: mc_rd=%0d cnt=%0d exp 0 0", mc_rd, stall_cnt); end
    clr();
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    clr();
    rs1_EX = 5'd5; rs2_EX = 5'd5; rd_MEM = 5'd5; rd_WB = 5'd5; RegWen_MEM = 1'b1; RegWen_WB = 1'b1;
    #1;
    checks++; if ({forwardA_EX, forwardB_EX} !== 4'b1111) begin errors++; $display("FAIL fwd_mem_prio: got %b exp 1111", {forwardA_EX, forwardB_EX}); end
    RegWen_MEM = 1'b0; #1;
    checks++; if ({forwardA_EX, forwardB_EX} !== 4'b1010) begin errors++; $display("FAIL fwd_wb: got %b exp 1010", {forwardA_EX, forwardB_EX}); end
    ASel_EX = 1'b1; #1;
    checks++; if ({forwardA_EX, forwardB_EX} !== 4'b0110) begin errors++; $display("FAIL fwd_asel: got %b exp 0110", {forwardA_EX, forwardB_EX}); end
    ASel_EX = 1'b0; RegWen_MEM = 1'b1; RegWen_WB = 1'b0; rd_WB = 5'd6; rs2_EX = 5'd6; #1;
    checks++; if ({forwardA_EX, forwardB_EX} !== 4'b1100) begin errors++; $display("FAIL fwd_mix: got %b exp 1100", {forwardA_EX, forwardB_EX}); end
    RegWen_WB = 1'b1; rs1_EX = 5'd0; rs2_EX = 5'd0; rd_MEM = 5'd0; rd_WB = 5'd0; #1;
    checks++; if ({forwardA_EX, forwardB_EX} !== 4'b0000) begin errors++; $display("FAIL fwd_x0: got %b exp 0000", {forwardA_EX, forwardB_EX}); end
    clr();
    tick();
  endtask

  task automatic test_load_use();
    clr();
    MemRead_EX = 1'b1; RegWen_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; #1;
    checks++; if ({stall_IF, stall_ID, bubble_EX} !== 3'b111) begin errors++; $display("FAIL ld_stall: got %b exp 111", {stall_IF, stall_ID, bubble_EX}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL ld_cnt0: got %0d exp 0", stall_cnt); end
    tick();
    clr(); #1;
    checks++; if ({stall_IF, stall_ID, bubble_EX} !== 3'b000) begin errors++; $display("FAIL ld_release: got %b exp 000", {stall_IF, stall_ID, bubble_EX}); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt1: got %0d exp 1", stall_cnt); end
    MemRead_EX = 1'b1; RegWen_EX = 1'b1; rd_EX = 5'd0; rs1_ID = 5'd0; #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL ld_x0: got %b exp 0", stall_ID); end
    rd_EX = 5'd8; rs1_ID = 5'd8; RegWen_EX = 1'b0; #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL ld_noregwen: got %b exp 0", stall_ID); end
    clr();
    tick();
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt_hold: got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_mc_raw();
    clr();
    mc_start_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; #1;
    checks++; if ({mc_busy, stall_ID} !== 2'b00) begin errors++; $display("FAIL raw_T: got %b exp 00", {mc_busy, stall_ID}); end
    tick();
    mc_start_EX = 1'b0; rd_EX = 5'd0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if ({mc_busy, mc_done, stall_IF, stall_ID, bubble_EX} !== 5'b10111 || mc_rd !== 5'd9) begin
        errors++; $display("FAIL raw_T+%0d: got busy/done/stalls=%b mc_rd=%0d exp 10111 9", k, {mc_busy, mc_done, stall_IF, stall_ID, bubble_EX}, mc_rd);
      end
      tick();
    end
    checks++; if ({mc_busy, mc_done, stall_ID} !== 3'b110) begin errors++; $display("FAIL raw_T+4: got %b exp 110", {mc_busy, mc_done, stall_ID}); end
    tick();
    checks++; if ({mc_busy, mc_done, stall_ID} !== 3'b000) begin errors++; $display("FAIL raw_T+5: got %b exp 000", {mc_busy, mc_done, stall_ID}); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL raw_cnt: got %0d exp 4", stall_cnt); end
    clr();
  endtask

  task automatic test_struct_waw_back_to_back();
    clr();
    mc_start_EX = 1'b1; rd_EX = 5'd3;
    tick();
    clr(); rs1_ID = 5'd1; rs2_ID = 5'd2; mc_req_ID = 1'b1; #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL struct: got %b exp 1", stall_ID); end
    mc_req_ID = 1'b0; RegWen_ID = 1'b1; rd_ID = 5'd3; #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL waw: got %b exp 1", stall_ID); end
    rd_ID = 5'd4; #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL waw_other: got %b exp 0", stall_ID); end
    clr();
    tick(); tick(); tick();
    checks++; if (mc_done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b exp 1", mc_done); end
    mc_start_EX = 1'b1; rd_EX = 5'd12;
    tick();
    clr();
    checks++; if ({mc_busy, mc_done} !== 2'b10 || mc_rd !== 5'd12) begin errors++; $display("FAIL b2b_reload: busy/done=%b mc_rd=%0d exp 10 12", {mc_busy, mc_done}, mc_rd); end
    tick(); tick();
    checks++; if ({mc_busy, mc_done} !== 2'b10) begin errors++; $display("FAIL b2b_T+3: got %b exp 10", {mc_busy, mc_done}); end
    tick();
    checks++; if ({mc_busy, mc_done} !== 2'b11) begin errors++; $display("FAIL b2b_done2: got %b exp 11", {mc_busy, mc_done}); end
    tick();
    checks++; if (mc_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", mc_busy); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt: got %0d exp 4", stall_cnt); end
  endtask

  task automatic test_mc_rd_zero();
    clr();
    mc_start_EX = 1'b1; rd_EX = 5'd0;
    tick();
    clr(); rs1_ID = 5'd0; RegWen_ID = 1'b1; rd_ID = 5'd0; #1;
    checks++; if ({mc_busy, stall_ID} !== 2'b10) begin errors++; $display("FAIL mcrd0: got %b exp 10", {mc_busy, stall_ID}); end
    clr();
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset_midop();
    clr();
    mc_start_EX = 1'b1; rd_EX = 5'd9;
    tick();
    mc_start_EX = 1'b0; rd_EX = 5'd0; rs1_ID = 5'd9;
    tick();
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b exp 1", stall_ID); end
    rst_n = 1'b0; #1;
    checks++; if ({mc_busy, stall_IF, stall_ID, bubble_EX} !== 4'b0000) begin errors++; $display("FAIL mid_async: got %b exp 0000", {mc_busy, stall_IF, stall_ID, bubble_EX}); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt: got %0d exp 0", stall_cnt); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({mc_busy, mc_done, stall_ID} !== 3'b000) begin errors++; $display("FAIL mid_after%0d: got %b exp 000", k, {mc_busy, mc_done, stall_ID}); end
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mc_raw();
    test_struct_waw_back_to_back();
    test_mc_rd_zero();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
